// File: rtl/regfile_write_arbiter.sv
// Shares the single RegisterFile write port between ALU writeback (requester 0)
// and load writeback (requester 1). After reset it clears every register to
// CLEAR_VALUE, then arbitrates the two requesters round-robin.
module regfile_write_arbiter #(
    parameter int unsigned           NUM_REGS    = 32,
    parameter int unsigned           ADDR_W      = 5,
    parameter int unsigned           DATA_W      = 32,
    parameter int unsigned           CNT_W       = 16,
    parameter logic [DATA_W-1:0]     CLEAR_VALUE = '0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req0Valid,
    input  logic [ADDR_W-1:0] Req0Reg,
    input  logic [DATA_W-1:0] Req0Data,
    output logic              Req0Ready,
    input  logic              Req1Valid,
    input  logic [ADDR_W-1:0] Req1Reg,
    input  logic [DATA_W-1:0] Req1Data,
    output logic              Req1Ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic              InitBusy,
    output logic [CNT_W-1:0]  ContentionCnt
);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    state_t            state;
    logic [ADDR_W-1:0] clearIdx;
    logic              rrPtr;
    logic              bothValid;

    // Grant decode: only in RUN, pointer breaks ties when both are valid.
    always_comb begin
        bothValid = Req0Valid & Req1Valid;
        Req0Ready = 1'b0;
        Req1Ready = 1'b0;
        if (state == RUN) begin
            Req0Ready = Req0Valid & (~Req1Valid | ~rrPtr);
            Req1Ready = Req1Valid & (~Req0Valid |  rrPtr);
        end
    end

    // Clear sequencer, arbitration state and registered write-port outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= CLEAR;
            clearIdx      <= '0;
            rrPtr         <= 1'b0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            InitBusy      <= 1'b1;
            ContentionCnt <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    RegWrite      <= 1'b1;
                    WriteRegister <= clearIdx;
                    WriteData     <= CLEAR_VALUE;
                    clearIdx      <= clearIdx + ADDR_W'(1);
                    if (clearIdx == LAST_IDX) begin
                        state    <= RUN;
                        InitBusy <= 1'b0;
                    end
                end
                RUN: begin
                    // Register 0 is hardwired: the handshake completes but the write is dropped.
                    if (Req0Ready) begin
                        RegWrite      <= (Req0Reg != '0);
                        WriteRegister <= Req0Reg;
                        WriteData     <= Req0Data;
                    end else if (Req1Ready) begin
                        RegWrite      <= (Req1Reg != '0);
                        WriteRegister <= Req1Reg;
                        WriteData     <= Req1Data;
                    end else begin
                        RegWrite      <= 1'b0;
                    end
                    // A contended cycle always grants one side, so the pointer hands off.
                    if (bothValid) begin
                        rrPtr <= ~rrPtr;
                        if (ContentionCnt != CNT_MAX) begin
                            ContentionCnt <= ContentionCnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a narrow contention counter.
module tb_regfile_write_arbiter;

    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 4;

    logic          Clk;
    logic          Rst_n;
    logic          Req0Valid, Req1Valid;
    logic [AW-1:0] Req0Reg, Req1Reg;
    logic [DW-1:0] Req0Data, Req1Data;
    logic          Req0Ready, Req1Ready;
    logic          RegWrite;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic          InitBusy;
    logic [CW-1:0] ContentionCnt;

    logic [DW-1:0] mem [NREGS];

    int passCnt  = 0;
    int totalCnt = 0;

    regfile_write_arbiter #(
        .NUM_REGS(NREGS), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .CLEAR_VALUE('0)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Req0Valid(Req0Valid), .Req0Reg(Req0Reg), .Req0Data(Req0Data), .Req0Ready(Req0Ready),
        .Req1Valid(Req1Valid), .Req1Reg(Req1Reg), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .InitBusy(InitBusy), .ContentionCnt(ContentionCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file behind the write port.
    always @(posedge Clk) begin
        if (RegWrite) mem[WriteRegister] <= WriteData;
    end

    task automatic test_reset();
        Rst_n = 1'b0;
        Req0Valid = 1'b1; Req0Reg = 5'd3; Req0Data = 32'h33;
        Req1Valid = 1'b0; Req1Reg = '0;   Req1Data = '0;
        @(negedge Clk); #1;
        totalCnt++; if (RegWrite !== 1'b0) $display("FAIL rst_we: got %0b want 0", RegWrite); else passCnt++;
        totalCnt++; if (WriteRegister !== 5'd0) $display("FAIL rst_wr: got %0d want 0", WriteRegister); else passCnt++;
        totalCnt++; if (WriteData !== 32'd0) $display("FAIL rst_wd: got %h want 0", WriteData); else passCnt++;
        totalCnt++; if (InitBusy !== 1'b1) $display("FAIL rst_busy: got %0b want 1", InitBusy); else passCnt++;
        totalCnt++; if (ContentionCnt !== 4'd0) $display("FAIL rst_cnt: got %0d want 0", ContentionCnt); else passCnt++;
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_clear();
        for (int i = 0; i < NREGS; i++) begin
            @(posedge Clk); #1;
            totalCnt++; if (RegWrite !== 1'b1) $display("FAIL clr_we[%0d]: got %0b want 1", i, RegWrite); else passCnt++;
            totalCnt++; if (WriteRegister !== AW'(i)) $display("FAIL clr_wr[%0d]: got %0d want %0d", i, WriteRegister, i); else passCnt++;
            totalCnt++; if (WriteData !== 32'd0) $display("FAIL clr_wd[%0d]: got %h want 0", i, WriteData); else passCnt++;
            if (i < NREGS - 1) begin
                totalCnt++; if (InitBusy !== 1'b1) $display("FAIL clr_busy[%0d]: got %0b want 1", i, InitBusy); else passCnt++;
                totalCnt++; if (Req0Ready !== 1'b0) $display("FAIL clr_rdy[%0d]: got %0b want 0", i, Req0Ready); else passCnt++;
            end
        end
        totalCnt++; if (InitBusy !== 1'b0) $display("FAIL clr_done_busy: got %0b want 0", InitBusy); else passCnt++;
        totalCnt++; if (Req0Ready !== 1'b1) $display("FAIL held_rdy: got %0b want 1", Req0Ready); else passCnt++;
        @(posedge Clk); #1;
        Req0Valid = 1'b0;
        totalCnt++; if (RegWrite !== 1'b1) $display("FAIL held_we: got %0b want 1", RegWrite); else passCnt++;
        totalCnt++; if (WriteRegister !== 5'd3) $display("FAIL held_wr: got %0d want 3", WriteRegister); else passCnt++;
        totalCnt++; if (WriteData !== 32'h33) $display("FAIL held_wd: got %h want 33", WriteData); else passCnt++;
        @(posedge Clk); #1;
        totalCnt++; if (RegWrite !== 1'b0) $display("FAIL idle_we: got %0b want 0", RegWrite); else passCnt++;
    endtask

    task automatic test_single();
        @(negedge Clk);
        Req0Valid = 1'b1; Req0Reg = 5'd8; Req0Data = 32'h11;
        #1;
        totalCnt++; if (Req0Ready !== 1'b1) $display("FAIL single_rdy0: got %0b want 1", Req0Ready); else passCnt++;
        totalCnt++; if (Req1Ready !== 1'b0) $display("FAIL single_rdy1: got %0b want 0", Req1Ready); else passCnt++;
        @(posedge Clk); #1;
        Req0Valid = 1'b0;
        totalCnt++; if (RegWrite !== 1'b1) $display("FAIL single_we: got %0b want 1", RegWrite); else passCnt++;
        totalCnt++; if (WriteRegister !== 5'd8) $display("FAIL single_wr: got %0d want 8", WriteRegister); else passCnt++;
        totalCnt++; if (WriteData !== 32'h11) $display("FAIL single_wd: got %h want 11", WriteData); else passCnt++;
        @(posedge Clk); #1;
        totalCnt++; if (RegWrite !== 1'b0) $display("FAIL single_idle: got %0b want 0", RegWrite); else passCnt++;
        totalCnt++; if (mem[8] !== 32'h11) $display("FAIL single_mem8: got %h want 11", mem[8]); else passCnt++;
    endtask

    task automatic test_contention();
        logic expR0;
        @(negedge Clk);
        Req0Valid = 1'b1; Req0Reg = 5'd9;  Req0Data = 32'hA;
        Req1Valid = 1'b1; Req1Reg = 5'd10; Req1Data = 32'hB;
        for (int k = 0; k < 6; k++) begin
            expR0 = (k % 2 == 0);
            #1;
            totalCnt++; if (Req0Ready !== expR0) $display("FAIL rr_rdy0[%0d]: got %0b want %0b", k, Req0Ready, expR0); else passCnt++;
            totalCnt++; if (Req1Ready !== !expR0) $display("FAIL rr_rdy1[%0d]: got %0b want %0b", k, Req1Ready, !expR0); else passCnt++;
            @(posedge Clk); #1;
            totalCnt++; if (WriteRegister !== (expR0 ? 5'd9 : 5'd10)) $display("FAIL rr_wr[%0d]: got %0d want %0d", k, WriteRegister, expR0 ? 9 : 10); else passCnt++;
            totalCnt++; if (WriteData !== (expR0 ? 32'hA : 32'hB)) $display("FAIL rr_wd[%0d]: got %h want %h", k, WriteData, expR0 ? 32'hA : 32'hB); else passCnt++;
            totalCnt++; if (RegWrite !== 1'b1) $display("FAIL rr_we[%0d]: got %0b want 1", k, RegWrite); else passCnt++;
            totalCnt++; if (ContentionCnt !== CW'(k + 1)) $display("FAIL rr_cnt[%0d]: got %0d want %0d", k, ContentionCnt, k + 1); else passCnt++;
            @(negedge Clk);
        end
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        @(posedge Clk); #1;
        totalCnt++; if (mem[10] !== 32'hB) $display("FAIL rr_mem10: got %h want b", mem[10]); else passCnt++;
        totalCnt++; if (ContentionCnt !== 4'd6) $display("FAIL rr_cnt_hold: got %0d want 6", ContentionCnt); else passCnt++;
    endtask

    task automatic test_reg0();
        @(negedge Clk);
        Req1Valid = 1'b1; Req1Reg = 5'd0; Req1Data = 32'hFF;
        #1;
        totalCnt++; if (Req1Ready !== 1'b1) $display("FAIL r0_rdy: got %0b want 1", Req1Ready); else passCnt++;
        @(posedge Clk); #1;
        Req1Valid = 1'b0;
        totalCnt++; if (RegWrite !== 1'b0) $display("FAIL r0_we: got %0b want 0", RegWrite); else passCnt++;
        totalCnt++; if (WriteData !== 32'hFF) $display("FAIL r0_wd: got %h want ff", WriteData); else passCnt++;
        @(posedge Clk); #1;
        totalCnt++; if (mem[0] !== 32'd0) $display("FAIL r0_mem0: got %h want 0", mem[0]); else passCnt++;
    endtask

    task automatic test_same_index();
        @(negedge Clk);
        Req0Valid = 1'b1; Req0Reg = 5'd12; Req0Data = 32'h1;
        Req1Valid = 1'b1; Req1Reg = 5'd12; Req1Data = 32'h2;
        #1;
        totalCnt++; if (Req0Ready !== 1'b1) $display("FAIL same_rdy0: got %0b want 1", Req0Ready); else passCnt++;
        @(posedge Clk); #1;
        Req0Valid = 1'b0;
        totalCnt++; if (Req1Ready !== 1'b1) $display("FAIL same_rdy1: got %0b want 1", Req1Ready); else passCnt++;
        @(posedge Clk); #1;
        Req1Valid = 1'b0;
        totalCnt++; if (WriteData !== 32'h2) $display("FAIL same_wd: got %h want 2", WriteData); else passCnt++;
        @(posedge Clk); #1;
        totalCnt++; if (mem[12] !== 32'h2) $display("FAIL same_mem12: got %h want 2", mem[12]); else passCnt++;
        totalCnt++; if (ContentionCnt !== 4'd7) $display("FAIL same_cnt: got %0d want 7", ContentionCnt); else passCnt++;
    endtask

    task automatic test_saturate();
        int expCnt;
        expCnt = 7;
        @(negedge Clk);
        Req0Valid = 1'b1; Req0Reg = 5'd1; Req0Data = 32'h5;
        Req1Valid = 1'b1; Req1Reg = 5'd2; Req1Data = 32'h6;
        for (int k = 0; k < (1 << CW) + 3; k++) begin
            @(posedge Clk); #1;
            expCnt = (expCnt < 15) ? expCnt + 1 : 15;
            totalCnt++; if (ContentionCnt !== CW'(expCnt)) $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, ContentionCnt, expCnt); else passCnt++;
        end
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        @(posedge Clk); #1;
        totalCnt++; if (ContentionCnt !== 4'd15) $display("FAIL sat_hold: got %0d want 15", ContentionCnt); else passCnt++;
    endtask

    task automatic test_reset_midflight();
        int waitCyc;
        // 7 + 19 contended cycles so far: pointer back at 0, R0 wins, pointer moves to 1.
        @(negedge Clk);
        Req0Valid = 1'b1; Req0Reg = 5'd5; Req0Data = 32'h55;
        Req1Valid = 1'b1; Req1Reg = 5'd6; Req1Data = 32'h66;
        #1;
        totalCnt++; if (Req0Ready !== 1'b1) $display("FAIL mid_rdy0: got %0b want 1", Req0Ready); else passCnt++;
        @(posedge Clk); #1;
        totalCnt++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd5) $display("FAIL mid_inflight: got we=%0b wr=%0d want we=1 wr=5", RegWrite, WriteRegister); else passCnt++;
        #1 Rst_n = 1'b0;
        #1;
        totalCnt++; if (RegWrite !== 1'b0) $display("FAIL mid_we: got %0b want 0", RegWrite); else passCnt++;
        totalCnt++; if (InitBusy !== 1'b1) $display("FAIL mid_busy: got %0b want 1", InitBusy); else passCnt++;
        totalCnt++; if (ContentionCnt !== 4'd0) $display("FAIL mid_cnt: got %0d want 0", ContentionCnt); else passCnt++;
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        totalCnt++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd0) $display("FAIL mid_restart: got we=%0b wr=%0d want we=1 wr=0", RegWrite, WriteRegister); else passCnt++;
        waitCyc = 0;
        while (InitBusy === 1'b1 && waitCyc < 40) begin
            @(posedge Clk); #1;
            waitCyc++;
        end
        totalCnt++; if (InitBusy !== 1'b0) $display("FAIL mid_clear_timeout: got busy=%0b want 0", InitBusy); else passCnt++;
        @(negedge Clk);
        Req0Valid = 1'b1; Req1Valid = 1'b1;
        #1;
        totalCnt++; if (Req0Ready !== 1'b1 || Req1Ready !== 1'b0) $display("FAIL mid_ptr: got r0=%0b r1=%0b want r0=1 r1=0", Req0Ready, Req1Ready); else passCnt++;
        @(negedge Clk);
        Req0Valid = 1'b0; Req1Valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clear();
        test_single();
        test_contention();
        test_reg0();
        test_same_index();
        test_saturate();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
